// File: rtl/decode_stage_pipe_if.sv
// Decode-to-execute bundle: decode-side inputs, write-back port, and ID/EX outputs.
interface decode_stage_pipe_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned CTRL_W = 12,
  parameter int unsigned STAT_W = 16
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [31:0]       InstrD;
  logic              ValidD;
  logic [XLEN-1:0]   PCD;
  logic [XLEN-1:0]   PCPlusD;
  logic [CTRL_W-1:0] CtrlD;
  logic [XLEN-1:0]   ImmExtD;
  logic              RegWriteW;
  logic [AW-1:0]     RDW;
  logic [XLEN-1:0]   ResultW;
  logic              FlushE;
  logic              StallIn;

  logic [CTRL_W-1:0] CtrlE;
  logic [XLEN-1:0]   RD1E;
  logic [XLEN-1:0]   RD2E;
  logic [XLEN-1:0]   ImmExtE;
  logic [AW-1:0]     RS1E;
  logic [AW-1:0]     RS2E;
  logic [AW-1:0]     RDE;
  logic [XLEN-1:0]   PCE;
  logic [XLEN-1:0]   PCPlusE;
  logic              ValidE;
  logic              StallF;
  logic              StallD;
  logic [STAT_W-1:0] LoadUseCnt;

  modport master (
    output InstrD, ValidD, PCD, PCPlusD, CtrlD, ImmExtD,
    output RegWriteW, RDW, ResultW, FlushE, StallIn,
    input  CtrlE, RD1E, RD2E, ImmExtE, RS1E, RS2E, RDE,
    input  PCE, PCPlusE, ValidE, StallF, StallD, LoadUseCnt
  );

  modport slave (
    input  InstrD, ValidD, PCD, PCPlusD, CtrlD, ImmExtD,
    input  RegWriteW, RDW, ResultW, FlushE, StallIn,
    output CtrlE, RD1E, RD2E, ImmExtE, RS1E, RS2E, RDE,
    output PCE, PCPlusE, ValidE, StallF, StallD, LoadUseCnt
  );
endinterface

// File: rtl/decode_stage_pipe.sv
// Decode stage: register file with write-back bypass, load-use hazard
// detection, and the ID/EX pipeline register with flush/stall/bubble.
module decode_stage_pipe #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREGS     = 32,
  parameter int unsigned CTRL_W    = 12,
  parameter int unsigned BYPASS_WB = 1,
  parameter int unsigned STAT_W    = 16
) (
  input logic                clk,
  input logic                rst,
  decode_stage_pipe_if.slave bus
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [XLEN-1:0]   rf_q [1:NREGS-1];

  logic [AW-1:0]     rs1, rs2, rdd;
  logic [XLEN-1:0]   rd1, rd2;
  logic              loadhaz;
  logic              unused_instr;

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [XLEN-1:0]   rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [XLEN-1:0]   pc_q, pc_d, pcp_q, pcp_d;
  logic [AW-1:0]     rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [STAT_W-1:0] cnt_q, cnt_d;

  assign rs1 = bus.InstrD[15 +: AW];
  assign rs2 = bus.InstrD[20 +: AW];
  assign rdd = bus.InstrD[7 +: AW];
  assign unused_instr = ^bus.InstrD;

  // Register file write; x0 has no storage, so writes to it vanish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_q <= '{default: '0};
    end else if (bus.RegWriteW && (bus.RDW != '0)) begin
      rf_q[bus.RDW] <= bus.ResultW;
    end
  end

  // Combinational read ports with optional same-cycle write-back forwarding.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs1 != '0) begin
      rd1 = ((BYPASS_WB != 0) && bus.RegWriteW && (bus.RDW == rs1)) ? bus.ResultW : rf_q[rs1];
    end
    if (rs2 != '0) begin
      rd2 = ((BYPASS_WB != 0) && bus.RegWriteW && (bus.RDW == rs2)) ? bus.ResultW : rf_q[rs2];
    end
  end

  // A load in EX whose destination feeds either decode source forces a bubble.
  assign loadhaz = valid_q & ctrl_q[3] & ctrl_q[0] & (rd_q != '0) & bus.ValidD &
                   ((rd_q == rs1) | (rd_q == rs2));

  assign bus.StallF = ~rst & (loadhaz | bus.StallIn);
  assign bus.StallD = ~rst & (loadhaz | bus.StallIn);

  // ID/EX next state: flush, then external stall, then load-use bubble, then capture.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    pcp_d   = pcp_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (bus.FlushE || (!bus.StallIn && loadhaz)) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      rd1_d   = '0;
      rd2_d   = '0;
      imm_d   = '0;
      pc_d    = '0;
      pcp_d   = '0;
      rs1_d   = '0;
      rs2_d   = '0;
      rd_d    = '0;
      if (!bus.FlushE && (cnt_q != '1)) begin
        cnt_d = cnt_q + STAT_W'(1);
      end
    end else if (!bus.StallIn) begin
      valid_d = bus.ValidD;
      ctrl_d  = bus.ValidD ? bus.CtrlD : '0;
      rd1_d   = rd1;
      rd2_d   = rd2;
      imm_d   = bus.ImmExtD;
      pc_d    = bus.PCD;
      pcp_d   = bus.PCPlusD;
      rs1_d   = rs1;
      rs2_d   = rs2;
      rd_d    = rdd;
    end
  end

  // ID/EX register and load-use counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      pcp_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      pcp_q   <= pcp_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ValidE     = valid_q;
  assign bus.CtrlE      = ctrl_q;
  assign bus.RD1E       = rd1_q;
  assign bus.RD2E       = rd2_q;
  assign bus.ImmExtE    = imm_q;
  assign bus.PCE        = pc_q;
  assign bus.PCPlusE    = pcp_q;
  assign bus.RS1E       = rs1_q;
  assign bus.RS2E       = rs2_q;
  assign bus.RDE        = rd_q;
  assign bus.LoadUseCnt = cnt_q;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: two instances (bypass on / 16-bit counter,
// bypass off / 2-bit counter) driven identically and checked against a model.
module tb_decode_stage_pipe;
  logic        clk;
  logic        rst;
  logic [31:0] InstrD;
  logic        ValidD;
  logic [31:0] PCD, PCPlusD, ImmExtD, ResultW;
  logic [11:0] CtrlD;
  logic        RegWriteW, FlushE, StallIn;
  logic [4:0]  RDW;

  int total = 0;
  int bad   = 0;

  decode_stage_pipe_if #(.XLEN(32), .NREGS(32), .CTRL_W(12), .STAT_W(16)) if0 ();
  decode_stage_pipe_if #(.XLEN(32), .NREGS(32), .CTRL_W(12), .STAT_W(2))  if1 ();

  assign if0.InstrD = InstrD;   assign if1.InstrD = InstrD;
  assign if0.ValidD = ValidD;   assign if1.ValidD = ValidD;
  assign if0.PCD = PCD;         assign if1.PCD = PCD;
  assign if0.PCPlusD = PCPlusD; assign if1.PCPlusD = PCPlusD;
  assign if0.CtrlD = CtrlD;     assign if1.CtrlD = CtrlD;
  assign if0.ImmExtD = ImmExtD; assign if1.ImmExtD = ImmExtD;
  assign if0.RegWriteW = RegWriteW; assign if1.RegWriteW = RegWriteW;
  assign if0.RDW = RDW;         assign if1.RDW = RDW;
  assign if0.ResultW = ResultW; assign if1.ResultW = ResultW;
  assign if0.FlushE = FlushE;   assign if1.FlushE = FlushE;
  assign if0.StallIn = StallIn; assign if1.StallIn = StallIn;

  decode_stage_pipe #(.XLEN(32), .NREGS(32), .CTRL_W(12), .BYPASS_WB(1), .STAT_W(16)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave));
  decode_stage_pipe #(.XLEN(32), .NREGS(32), .CTRL_W(12), .BYPASS_WB(0), .STAT_W(2)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural registers plus the EX-slot contents per variant.
  logic [31:0] mRF [32];
  logic        mV [2];
  logic [11:0] mC [2];
  logic [31:0] mRD1 [2], mRD2 [2], mImm [2], mPC [2], mPCP [2];
  logic [4:0]  mRS1 [2], mRS2 [2], mRD [2];
  int unsigned mCnt [2];

  function automatic logic [31:0] mk(input int rd, input int r1, input int r2);
    logic [31:0] w;
    w = 32'h0000_0033;
    w[11:7]  = 5'(rd);
    w[19:15] = 5'(r1);
    w[24:20] = 5'(r2);
    return w;
  endfunction

  function automatic logic m_haz(input int v);
    logic [4:0] a, b;
    a = InstrD[19:15];
    b = InstrD[24:20];
    return mV[v] && mC[v][3] && mC[v][0] && (mRD[v] != 0) && ValidD &&
           (mRD[v] == a || mRD[v] == b);
  endfunction

  function automatic logic [31:0] m_read(input int v, input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (v == 0 && RegWriteW && RDW == idx) return ResultW;
    return mRF[idx];
  endfunction

  task automatic m_clear_slot(input int v);
    mV[v] = 0; mC[v] = 0; mRD1[v] = 0; mRD2[v] = 0; mImm[v] = 0;
    mPC[v] = 0; mPCP[v] = 0; mRS1[v] = 0; mRS2[v] = 0; mRD[v] = 0;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) mRF[i] = 0;
    for (int v = 0; v < 2; v++) begin
      m_clear_slot(v);
      mCnt[v] = 0;
    end
  endtask

  task automatic m_clock();
    logic hz [2];
    logic [31:0] r1 [2], r2 [2];
    for (int v = 0; v < 2; v++) begin
      hz[v] = m_haz(v);
      r1[v] = m_read(v, InstrD[19:15]);
      r2[v] = m_read(v, InstrD[24:20]);
    end
    for (int v = 0; v < 2; v++) begin
      if (FlushE) m_clear_slot(v);
      else if (StallIn) begin end
      else if (hz[v]) begin
        m_clear_slot(v);
        if (mCnt[v] < ((v == 0) ? 65535 : 3)) mCnt[v]++;
      end else begin
        mV[v] = ValidD; mC[v] = ValidD ? CtrlD : 12'h0;
        mRD1[v] = r1[v]; mRD2[v] = r2[v]; mImm[v] = ImmExtD;
        mPC[v] = PCD; mPCP[v] = PCPlusD;
        mRS1[v] = InstrD[19:15]; mRS2[v] = InstrD[24:20]; mRD[v] = InstrD[11:7];
      end
    end
    if (RegWriteW && RDW != 0) mRF[RDW] = ResultW;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string p, input int v,
      input logic [11:0] ce, input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
      input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
      input logic [31:0] pc, input logic [31:0] pcp, input logic ve,
      input logic sf, input logic sd, input logic [15:0] cnt);
    logic st;
    st = rst ? 1'b0 : (m_haz(v) | StallIn);
    chk({p, ".ValidE"}, ve, mV[v]);
    chk({p, ".CtrlE"}, ce, mC[v]);
    chk({p, ".RD1E"}, a, mRD1[v]);
    chk({p, ".RD2E"}, b, mRD2[v]);
    chk({p, ".ImmExtE"}, im, mImm[v]);
    chk({p, ".RS1E"}, s1, mRS1[v]);
    chk({p, ".RS2E"}, s2, mRS2[v]);
    chk({p, ".RDE"}, d, mRD[v]);
    chk({p, ".PCE"}, pc, mPC[v]);
    chk({p, ".PCPlusE"}, pcp, mPCP[v]);
    chk({p, ".StallF"}, sf, st);
    chk({p, ".StallD"}, sd, st);
    chk({p, ".LoadUseCnt"}, cnt, mCnt[v]);
  endtask

  task automatic check_all();
    check_dut("d0", 0, if0.CtrlE, if0.RD1E, if0.RD2E, if0.ImmExtE, if0.RS1E, if0.RS2E,
              if0.RDE, if0.PCE, if0.PCPlusE, if0.ValidE, if0.StallF, if0.StallD, if0.LoadUseCnt);
    check_dut("d1", 1, if1.CtrlE, if1.RD1E, if1.RD2E, if1.ImmExtE, if1.RS1E, if1.RS2E,
              if1.RDE, if1.PCE, if1.PCPlusE, if1.ValidE, if1.StallF, if1.StallD,
              16'(if1.LoadUseCnt));
  endtask

  // Called just after a negedge with inputs applied; returns at the next negedge.
  task automatic tick();
    #1;
    if (rst) m_reset();
    check_all();
    @(posedge clk);
    if (rst) m_reset(); else m_clock();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic idle();
    InstrD = 0; ValidD = 0; CtrlD = 0; RegWriteW = 0; RDW = 0; ResultW = 0;
    FlushE = 0; StallIn = 0; PCD = 0; PCPlusD = 0; ImmExtD = 0;
  endtask

  task automatic decode(input int rd, input int r1, input int r2, input logic [11:0] c);
    InstrD = mk(rd, r1, r2); ValidD = 1; CtrlD = c; RegWriteW = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    m_reset();
    @(negedge clk);

    // Reset with random inputs: everything reads zero, stalls suppressed.
    for (int i = 0; i < 3; i++) begin
      InstrD = $urandom; ValidD = 1; CtrlD = 12'($urandom); PCD = $urandom;
      RegWriteW = 1; RDW = 5'($urandom); ResultW = $urandom; StallIn = 1;
      tick();
      chk("rst_ValidE", if0.ValidE, 1'b0);
      chk("rst_StallD", if0.StallD, 1'b0);
    end
    rst = 0;
    idle();
    ValidD = 1; PCD = 32'h100; PCPlusD = 32'h104; CtrlD = 12'h001; InstrD = mk(1, 0, 0);
    tick();
    chk("post_rst_PCE", if0.PCE, 32'h100);
    chk("post_rst_CtrlE", if0.CtrlE, 12'h001);
    chk("post_rst_ValidE", if0.ValidE, 1'b1);

    // Write x5 then read it; write to x0 is dropped.
    idle(); RegWriteW = 1; RDW = 5; ResultW = 32'hDEADBEEF; tick();
    idle(); decode(1, 5, 0, 12'h001); tick();
    chk("rd_x5_d0", if0.RD1E, 32'hDEADBEEF);
    chk("rd_x5_d1", if1.RD1E, 32'hDEADBEEF);
    idle(); RegWriteW = 1; RDW = 0; ResultW = 32'hFFFF_FFFF; tick();
    idle(); decode(1, 0, 0, 12'h001); tick();
    chk("rd_x0", if0.RD1E, 32'h0);

    // Same-cycle write-back: forwarded only on the bypass instance.
    idle(); RegWriteW = 1; RDW = 7; ResultW = 32'h5555; tick();
    idle(); decode(1, 0, 7, 12'h001); RegWriteW = 1; RDW = 7; ResultW = 32'h1234; tick();
    chk("bypass_on", if0.RD2E, 32'h1234);
    chk("bypass_off", if1.RD2E, 32'h5555);

    // Load-use: one bubble, then the dependent add enters EX.
    idle(); decode(3, 0, 0, 12'h009); tick();
    idle(); decode(4, 3, 0, 12'h001);
    #1;
    chk("lu_StallD", if0.StallD, 1'b1);
    chk("lu_StallF", if0.StallF, 1'b1);
    #1;
    tick();
    chk("lu_bubble_ValidE", if0.ValidE, 1'b0);
    chk("lu_bubble_CtrlE", if0.CtrlE, 12'h000);
    chk("lu_cnt", if0.LoadUseCnt, 16'd1);
    chk("lu_released", if0.StallD, 1'b0);
    tick();
    chk("lu_add_ValidE", if0.ValidE, 1'b1);
    chk("lu_add_RS1E", if0.RS1E, 5'd3);
    idle(); decode(0, 0, 0, 12'h009); tick();
    idle(); decode(4, 0, 0, 12'h001);
    #1;
    chk("lu_rd0_nostall", if0.StallD, 1'b0);
    #1;
    tick();

    // Flush beats external stall and load-use; counter unchanged.
    idle(); decode(3, 0, 0, 12'h009); tick();
    idle(); decode(4, 3, 0, 12'h001); StallIn = 1; FlushE = 1; tick();
    chk("flush_ValidE", if0.ValidE, 1'b0);
    chk("flush_CtrlE", if0.CtrlE, 12'h000);
    chk("flush_cnt", if0.LoadUseCnt, 16'd1);

    // Five more load-use events: 2-bit counter pins at 3.
    for (int i = 0; i < 5; i++) begin
      idle(); decode(3, 0, 0, 12'h009); tick();
      idle(); decode(4, 0, 3, 12'h001); tick();
    end
    chk("sat_cnt_d1", if1.LoadUseCnt, 2'd3);
    chk("sat_cnt_d0", if0.LoadUseCnt, 16'd6);

    // Reset asserted while stalled: stalls drop before any clock edge.
    idle(); StallIn = 1; tick();
    rst = 1;
    #1;
    chk("rst_mid_stall", if0.StallD, 1'b0);
    #1;
    tick();
    rst = 0;
    idle();

    // Randomized phase with small register range to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      InstrD = $urandom;
      InstrD[11:7]  = 5'($urandom_range(0, 7));
      InstrD[19:15] = 5'($urandom_range(0, 7));
      InstrD[24:20] = 5'($urandom_range(0, 7));
      ValidD = ($urandom_range(0, 7) != 0);
      CtrlD = 12'($urandom);
      CtrlD[0] = ($urandom_range(0, 3) != 0);
      PCD = $urandom; PCPlusD = $urandom; ImmExtD = $urandom;
      RegWriteW = $urandom_range(0, 1) == 1;
      RDW = 5'($urandom_range(0, 7));
      ResultW = $urandom;
      FlushE = ($urandom_range(0, 9) == 0);
      StallIn = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
Parametrised decode stage for the 5-stage RISC-V pipeline. It contains a generic register file with a write-back-to-decode bypass, a load-use hazard detector, and the ID/EX pipeline register with stall, flush and valid tracking. It sits between the fetch/decoder logic and the execute stage. Control bits and the sign-extended immediate arrive pre-decoded as a bundle.

Parameters:
XLEN, 32, datapath and PC width in bits.
NREGS, 32, number of architectural registers; AW = $clog2(NREGS); x0 is hardwired to zero.
CTRL_W, 12, control bundle width; minimum 9.
BYPASS_WB, 1, 1 = a write-back to the same register in the same cycle is forwarded to the decode read ports.
STAT_W, 16, width of the load-use stall counter.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
InstrD  in  32  decode instruction; rs1=[19:15], rs2=[24:20], rd=[11:7], using the low AW bits of each field
ValidD  in  1  decode slot holds a real instruction
PCD, PCPlusD  in  XLEN  PC and PC+4 of the decode instruction
CtrlD  in  CTRL_W  control bundle: [0] RegWrite, [1] ALUSrc, [2] MemWrite, [3] ResultSrc (load), [4] Branch, [5] Jump, [8:6] ALUControl, rest spare
ImmExtD  in  XLEN  sign-extended immediate
RegWriteW  in  1  write-back enable
RDW  in  AW  write-back destination
ResultW  in  XLEN  write-back data
FlushE  in  1  taken branch/jump resolved in EX; kill the instruction entering EX
StallIn  in  1  external stall (memory); freeze ID/EX
CtrlE  out  CTRL_W  registered control bundle
RD1E, RD2E, ImmExtE  out  XLEN  registered operands and immediate
RS1E, RS2E, RDE  out  AW  registered register indices (for the forwarding unit)
PCE, PCPlusE  out  XLEN  registered PC values
ValidE  out  1  EX slot holds a real instruction
StallF, StallD  out  1  hold the PC and IF/ID registers
LoadUseCnt  out  STAT_W  saturating count of load-use bubbles

Behaviour:
- Reset: one clock, clk. rst is asynchronous and active-high. While rst=1, every ID/EX register, every register-file entry and LoadUseCnt are 0. All outputs are 0 during reset.
- Register file writes: NREGS x XLEN entries, written on posedge clk when RegWriteW=1 and RDW!=0. Writes to x0 are ignored, and reads of x0 always return 0.
- Register file reads: combinational. When BYPASS_WB=1, RegWriteW=1, RDW==rsN and rsN!=0, the port returns ResultW instead of the stored value. When BYPASS_WB=0, the stored value is returned and the new value is visible the next cycle.
- Load-use hazard: loadhaz = ValidE & CtrlE[3] & CtrlE[0] & (RDE!=0) & ValidD & (RDE==rs1 | RDE==rs2). The rs2 comparison is made for every instruction format (conservative).
- Stall outputs: StallF = StallD = loadhaz | StallIn. These are combinational and never asserted during reset.
- ID/EX update at posedge, one-cycle latency, evaluated in priority order:
  1. FlushE=1: ValidE<=0, CtrlE<=0, all data and index fields <=0. Flush wins over StallIn and loadhaz.
  2. StallIn=1: every ID/EX field holds its value.
  3. loadhaz=1: insert a bubble. ValidE<=0, CtrlE<=0, data fields <=0. The decode instruction is re-presented by the held IF/ID.
  4. Otherwise: capture all D-side values. ValidE<=ValidD. CtrlE<=ValidD ? CtrlD : 0.
- LoadUseCnt: increments by 1 on each cycle that applies case 3. It saturates at 2^STAT_W-1 and never wraps.
- Write-back in the same cycle as a stall: the register file is written regardless of StallIn, loadhaz or FlushE.
- Reset asserted mid-stall: stall outputs drop immediately and all state clears.

Test Plan:
1. Reset: hold rst=1 with random inputs -> all outputs 0. Release rst, apply ValidD=1, PCD=0x100, CtrlD=0x001 -> next cycle PCE=0x100, CtrlE=0x001, ValidE=1.
2. Write and read: RegWriteW=1, RDW=5, ResultW=0xDEADBEEF, then decode rs1=5 -> RD1E=0xDEADBEEF. A write to RDW=0 followed by a read of rs1=0 -> RD1E=0.
3. Bypass: in the same cycle, RegWriteW=1, RDW=7, ResultW=0x1234 and decode rs2=7 -> RD2E=0x1234 at the next edge (BYPASS_WB=1). Repeat with BYPASS_WB=0 -> old value of x7.
4. Load-use: EX holds a load with rd=3; decode add with rs1=3 -> StallD=1 for exactly 1 cycle, one bubble (ValidE=0, CtrlE=0), then the add enters EX. LoadUseCnt goes 0->1. With rd=0 -> no stall.
5. Flush priority: FlushE=1 together with StallIn=1 and loadhaz=1 -> ValidE=0, CtrlE=0 next cycle, and LoadUseCnt is unchanged.
6. Counter saturation: STAT_W=2, force 5 consecutive load-use events -> LoadUseCnt reaches 3 and stays at 3.
